// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and the
// default operand width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub4_full_subtractor.sv
// One-bit full subtractor. The serial datapath reuses this single cell for
// every bit position, one bit per CALC cycle.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    assign d     = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial subtractor: diff = a - b - b_in (mod 2^WIDTH), one bit per cycle,
// with valid/ready handshakes on both the operand and the result side.
module serial_sub4
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_b_out;
    logic             r_ovf;

    logic             w_accept;
    logic             w_calc;
    logic             w_last;
    logic             w_d;
    logic             w_borrow;

    full_subtractor u_fs (
        .a     (r_a[r_cnt]),
        .b     (r_b[r_cnt]),
        .b_in  (r_borrow),
        .d     (w_d),
        .b_out (w_borrow)
    );

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_calc   = (r_state == CALC);
    assign w_last   = w_calc && (r_cnt == LAST);

    // NOTE: async reset is in the sensitivity list; sequential state uses <= only,
    // so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = CALC;
            end
            CALC: begin
                if (r_cnt == LAST) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Result registers are cleared on acceptance so unprocessed bits read as 0
    // during CALC; outside CALC they simply hold the last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_b_out  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= b_in;
            r_cnt    <= '0;
            r_diff   <= '0;
        end else if (w_calc) begin
            r_diff[r_cnt] <= w_d;
            r_borrow      <= w_borrow;
            r_cnt         <= r_cnt + CW'(1);
            if (w_last) begin
                r_b_out <= w_borrow;
                // The MSB of diff is being produced this cycle, so use w_d directly.
                r_ovf   <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (r_a[WIDTH-1] ^ w_d);
            end
        end
    end

    assign diff  = r_diff;
    assign b_out = r_b_out;
    assign ovf   = r_ovf;

endmodule
